// File: rtl/ysyx_24100006_axi_defs.sv
// Shared AXI4-Lite definitions for the CLINT slice: response codes,
// FSM state encodings and the word offsets of the mtime registers.
package ysyx_24100006_axi_defs;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [31:0] OFFSET_LO = 32'd0;
    localparam logic [31:0] OFFSET_HI = 32'd4;

    typedef enum logic [1:0] {
        W_IDLE   = 2'd0,
        W_GOT_AW = 2'd1,
        W_GOT_W  = 2'd2,
        W_RESP   = 2'd3
    } w_state_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_RESP = 2'd2
    } r_state_t;

endpackage

// File: rtl/ysyx_24100006_clint_timer.sv
// Free-running 64-bit mtime with a prescaler and a byte-strobed write port
// per 32-bit word. A write replaces the increment for that cycle.
module ysyx_24100006_clint_timer #(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] wr_data,
    input  logic [3:0]  wr_strb,
    output logic [63:0] mtime
);

    localparam logic [15:0] PRESC_MAX = 16'(TICK_DIV - 1);

    logic [15:0] presc_reg, presc_next;
    logic [63:0] mtime_reg, mtime_next;
    logic [31:0] lo_merged, hi_merged;
    logic        tick;

    assign tick = (presc_reg == PRESC_MAX);

    // Unstrobed bytes keep the pre-increment value of the addressed word.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign lo_merged[8*gi +: 8] = wr_strb[gi] ? wr_data[8*gi +: 8] : mtime_reg[8*gi +: 8];
        assign hi_merged[8*gi +: 8] = wr_strb[gi] ? wr_data[8*gi +: 8] : mtime_reg[32+8*gi +: 8];
    end

    always_comb begin
        presc_next = tick ? 16'd0 : presc_reg + 16'd1;
        mtime_next = mtime_reg + 64'(tick);
        if (wr_lo || wr_hi) begin
            mtime_next = mtime_reg;
            if (wr_lo) begin
                mtime_next[31:0] = lo_merged;
            end
            if (wr_hi) begin
                mtime_next[63:32] = hi_merged;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_reg <= 16'd0;
            mtime_reg <= 64'd0;
        end else begin
            presc_reg <= presc_next;
            mtime_reg <= mtime_next;
        end
    end

    assign mtime = mtime_reg;

endmodule

// File: rtl/ysyx_24100006_clint.sv
// CLINT mtime responder on an AXI4-Lite slave port: independent write and
// read FSMs, word decode and registered responses around the timer.
module ysyx_24100006_clint
    import ysyx_24100006_axi_defs::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'ha000_0048,
    parameter int unsigned TICK_DIV     = 1,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        s_axi_awvalid,
    output logic        s_axi_awready,
    input  logic [31:0] s_axi_awaddr,
    input  logic        s_axi_wvalid,
    output logic        s_axi_wready,
    input  logic [31:0] s_axi_wdata,
    input  logic [7:0]  s_axi_wstrb,
    output logic        s_axi_bvalid,
    input  logic        s_axi_bready,
    output logic [1:0]  s_axi_bresp,
    input  logic        s_axi_arvalid,
    output logic        s_axi_arready,
    input  logic [31:0] s_axi_araddr,
    output logic        s_axi_rvalid,
    input  logic        s_axi_rready,
    output logic [31:0] s_axi_rdata,
    output logic [1:0]  s_axi_rresp
);

    localparam logic [31:0] LO_ADDR  = BASE_ADDR + OFFSET_LO;
    localparam logic [31:0] HI_ADDR  = BASE_ADDR + OFFSET_HI;
    localparam logic [29:0] LO_WORD  = LO_ADDR[31:2];
    localparam logic [29:0] HI_WORD  = HI_ADDR[31:2];
    localparam logic [3:0]  LAT_LOAD = 4'(READ_LATENCY - 1);

    w_state_t    w_state_reg, w_state_next;
    logic [29:0] aw_addr_reg;
    logic [31:0] w_data_reg;
    logic [3:0]  w_strb_reg;
    logic [1:0]  bresp_reg;
    logic        aw_hs, w_hs, commit;
    logic [29:0] cm_addr;
    logic [31:0] cm_data;
    logic [3:0]  cm_strb;
    logic        wr_lo, wr_hi;

    r_state_t    r_state_reg, r_state_next;
    logic [29:0] ar_addr_reg, sample_addr;
    logic [3:0]  lat_cnt_reg;
    logic [31:0] rdata_reg;
    logic [1:0]  rresp_reg;
    logic        sample;
    logic [63:0] mtime;
    logic        unused_bits;

    assign unused_bits = ^{s_axi_wstrb[7:4], s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    // ---------------- write channel ----------------
    assign s_axi_awready = (w_state_reg == W_IDLE) || (w_state_reg == W_GOT_W);
    assign s_axi_wready  = (w_state_reg == W_IDLE) || (w_state_reg == W_GOT_AW);
    assign s_axi_bvalid  = (w_state_reg == W_RESP);
    assign s_axi_bresp   = bresp_reg;
    assign aw_hs         = s_axi_awvalid && s_axi_awready;
    assign w_hs          = s_axi_wvalid && s_axi_wready;

    always_comb begin
        w_state_next = w_state_reg;
        commit       = 1'b0;
        case (w_state_reg)
            W_IDLE: begin
                if (aw_hs && w_hs) begin
                    commit       = 1'b1;
                    w_state_next = W_RESP;
                end else if (aw_hs) begin
                    w_state_next = W_GOT_AW;
                end else if (w_hs) begin
                    w_state_next = W_GOT_W;
                end
            end
            W_GOT_AW: begin
                if (w_hs) begin
                    commit       = 1'b1;
                    w_state_next = W_RESP;
                end
            end
            W_GOT_W: begin
                if (aw_hs) begin
                    commit       = 1'b1;
                    w_state_next = W_RESP;
                end
            end
            W_RESP: begin
                if (s_axi_bready) begin
                    w_state_next = W_IDLE;
                end
            end
            default: w_state_next = W_IDLE;
        endcase
    end

    // Whichever half arrived first was latched; the other comes live off the bus.
    assign cm_addr = (w_state_reg == W_GOT_AW) ? aw_addr_reg : s_axi_awaddr[31:2];
    assign cm_data = (w_state_reg == W_GOT_W)  ? w_data_reg  : s_axi_wdata;
    assign cm_strb = (w_state_reg == W_GOT_W)  ? w_strb_reg  : s_axi_wstrb[3:0];
    assign wr_lo   = commit && (cm_addr == LO_WORD);
    assign wr_hi   = commit && (cm_addr == HI_WORD);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            w_state_reg <= W_IDLE;
            aw_addr_reg <= 30'd0;
            w_data_reg  <= 32'd0;
            w_strb_reg  <= 4'd0;
            bresp_reg   <= RESP_OKAY;
        end else begin
            w_state_reg <= w_state_next;
            if (aw_hs) begin
                aw_addr_reg <= s_axi_awaddr[31:2];
            end
            if (w_hs) begin
                w_data_reg <= s_axi_wdata;
                w_strb_reg <= s_axi_wstrb[3:0];
            end
            if (commit) begin
                bresp_reg <= (wr_lo || wr_hi) ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    ysyx_24100006_clint_timer #(
        .TICK_DIV(TICK_DIV)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .wr_lo   (wr_lo),
        .wr_hi   (wr_hi),
        .wr_data (cm_data),
        .wr_strb (cm_strb),
        .mtime   (mtime)
    );

    // ---------------- read channel ----------------
    assign s_axi_arready = (r_state_reg == R_IDLE);
    assign s_axi_rvalid  = (r_state_reg == R_RESP);
    assign s_axi_rdata   = rdata_reg;
    assign s_axi_rresp   = rresp_reg;

    always_comb begin
        r_state_next = r_state_reg;
        sample       = 1'b0;
        sample_addr  = ar_addr_reg;
        case (r_state_reg)
            R_IDLE: begin
                if (s_axi_arvalid) begin
                    if (LAT_LOAD == 4'd0) begin
                        sample       = 1'b1;
                        sample_addr  = s_axi_araddr[31:2];
                        r_state_next = R_RESP;
                    end else begin
                        r_state_next = R_WAIT;
                    end
                end
            end
            R_WAIT: begin
                if (lat_cnt_reg <= 4'd1) begin
                    sample       = 1'b1;
                    r_state_next = R_RESP;
                end
            end
            R_RESP: begin
                if (s_axi_rready) begin
                    r_state_next = R_IDLE;
                end
            end
            default: r_state_next = R_IDLE;
        endcase
    end

    // mtime is the registered value, so a read sampled with a commit sees pre-write data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state_reg <= R_IDLE;
            ar_addr_reg <= 30'd0;
            lat_cnt_reg <= 4'd0;
            rdata_reg   <= 32'd0;
            rresp_reg   <= RESP_OKAY;
        end else begin
            r_state_reg <= r_state_next;
            if (r_state_reg == R_IDLE && s_axi_arvalid) begin
                ar_addr_reg <= s_axi_araddr[31:2];
                lat_cnt_reg <= LAT_LOAD;
            end else if (r_state_reg == R_WAIT) begin
                lat_cnt_reg <= lat_cnt_reg - 4'd1;
            end
            if (sample) begin
                if (sample_addr == LO_WORD) begin
                    rdata_reg <= mtime[31:0];
                    rresp_reg <= RESP_OKAY;
                end else if (sample_addr == HI_WORD) begin
                    rdata_reg <= mtime[63:32];
                    rresp_reg <= RESP_OKAY;
                end else begin
                    rdata_reg <= 32'd0;
                    rresp_reg <= RESP_SLVERR;
                end
            end
        end
    end

endmodule

// File: tb/tb_ysyx_24100006_clint.sv
// Directed bench for the CLINT: a TICK_DIV=1 instance and a TICK_DIV=1000
// instance share one stimulus bus; each sees identical handshake timing.
module tb_ysyx_24100006_clint;

    localparam logic [31:0] LO   = 32'ha000_0048;
    localparam logic [31:0] HI   = 32'ha000_004C;
    localparam logic [31:0] MISS = 32'ha000_0050;
    localparam logic [1:0]  OKAY = 2'b00;
    localparam logic [1:0]  SERR = 2'b10;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic [31:0] awaddr = 32'd0, wdata = 32'd0, araddr = 32'd0;
    logic [7:0]  wstrb = 8'd0;

    logic        f_awready, f_wready, f_bvalid, f_arready, f_rvalid;
    logic [1:0]  f_bresp, f_rresp;
    logic [31:0] f_rdata;
    logic        s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
    logic [1:0]  s_bresp, s_rresp;
    logic [31:0] s_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ysyx_24100006_clint #(.BASE_ADDR(LO), .TICK_DIV(1), .READ_LATENCY(1)) u_fast (
        .clk(clk), .reset(reset),
        .s_axi_awvalid(awvalid), .s_axi_awready(f_awready), .s_axi_awaddr(awaddr),
        .s_axi_wvalid(wvalid), .s_axi_wready(f_wready), .s_axi_wdata(wdata), .s_axi_wstrb(wstrb),
        .s_axi_bvalid(f_bvalid), .s_axi_bready(bready), .s_axi_bresp(f_bresp),
        .s_axi_arvalid(arvalid), .s_axi_arready(f_arready), .s_axi_araddr(araddr),
        .s_axi_rvalid(f_rvalid), .s_axi_rready(rready), .s_axi_rdata(f_rdata), .s_axi_rresp(f_rresp)
    );

    ysyx_24100006_clint #(.BASE_ADDR(LO), .TICK_DIV(1000), .READ_LATENCY(1)) u_slow (
        .clk(clk), .reset(reset),
        .s_axi_awvalid(awvalid), .s_axi_awready(s_awready), .s_axi_awaddr(awaddr),
        .s_axi_wvalid(wvalid), .s_axi_wready(s_wready), .s_axi_wdata(wdata), .s_axi_wstrb(wstrb),
        .s_axi_bvalid(s_bvalid), .s_axi_bready(bready), .s_axi_bresp(s_bresp),
        .s_axi_arvalid(arvalid), .s_axi_arready(s_arready), .s_axi_araddr(araddr),
        .s_axi_rvalid(s_rvalid), .s_axi_rready(rready), .s_axi_rdata(s_rdata), .s_axi_rresp(s_rresp)
    );

    // Clock edges since reset release; equals fast mtime until it is written.
    int cyc;
    always @(posedge clk or negedge reset) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    typedef struct {
        logic        wr_en;
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [1:0]  exp_bresp;
        logic [31:0] raddr;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_rresp;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic axi_read(input logic [31:0] a, input string nm,
                            output logic [31:0] df, output logic [31:0] ds,
                            output logic [1:0] rf, output logic [1:0] rs);
        int n;
        araddr  = a;
        arvalid = 1'b1;
        step(1);
        arvalid = 1'b0;
        n = 0;
        while (!f_rvalid && n < 20) begin
            step(1);
            n++;
        end
        check({nm, "_rlat"}, n, 0);
        df = f_rdata;
        ds = s_rdata;
        rf = f_rresp;
        rs = s_rresp;
        rready = 1'b1;
        step(1);
        rready = 1'b0;
        check({nm, "_rclr"}, {f_rvalid, f_arready}, 2'b01);
        $display("read  %s addr=%h fast=%h/%0d slow=%h/%0d", nm, a, df, rf, ds, rs);
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input string nm, output logic [1:0] bf, output logic [1:0] bs);
        awaddr  = a;
        wdata   = d;
        wstrb   = {4'hF, s};
        awvalid = 1'b1;
        wvalid  = 1'b1;
        step(1);
        awvalid = 1'b0;
        wvalid  = 1'b0;
        check({nm, "_bvalid"}, {f_bvalid, s_bvalid}, 2'b11);
        bf = f_bresp;
        bs = s_bresp;
        bready = 1'b1;
        step(1);
        bready = 1'b0;
        check({nm, "_bclr"}, {f_bvalid, f_awready, f_wready}, 3'b011);
        $display("write %s addr=%h data=%h strb=%h bresp=%0d/%0d", nm, a, d, s, bf, bs);
    endtask

    initial begin
        logic [31:0] df, ds;
        logic [1:0]  rf, rs, bf, bs;
        int guard;

        vecs[0] = '{1'b1, LO,            32'h1234_5678, 4'hF, OKAY, LO,            32'h1234_5678, OKAY};
        vecs[1] = '{1'b1, HI,            32'hDEAD_BEEF, 4'hF, OKAY, HI,            32'hDEAD_BEEF, OKAY};
        vecs[2] = '{1'b1, LO,            32'h0000_AB00, 4'h2, OKAY, LO,            32'h1234_AB78, OKAY};
        vecs[3] = '{1'b1, HI,            32'h1100_0022, 4'h9, OKAY, HI,            32'h11AD_BE22, OKAY};
        vecs[4] = '{1'b1, MISS,          32'hFFFF_FFFF, 4'hF, SERR, MISS,          32'h0000_0000, SERR};
        vecs[5] = '{1'b0, LO,            32'h0000_0000, 4'h0, OKAY, LO,            32'h1234_AB78, OKAY};
        vecs[6] = '{1'b1, 32'ha000_004A, 32'hCAFE_F00D, 4'h1, OKAY, LO,            32'h1234_AB0D, OKAY};
        vecs[7] = '{1'b1, 32'ha000_0044, 32'hFFFF_FFFF, 4'hF, SERR, 32'ha000_0044, 32'h0000_0000, SERR};
        vecs[8] = '{1'b0, LO,            32'h0000_0000, 4'h0, OKAY, 32'ha000_004F, 32'h11AD_BE22, OKAY};

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_ready", {f_awready, f_wready, f_arready}, 3'b111);
        check("rst_valid", {f_bvalid, f_rvalid}, 2'b00);
        check("rst_resp", {f_bresp, f_rresp}, 4'b0000);
        check("rst_rdata", f_rdata, 32'd0);

        // Idle 10 cycles after release: LO sampled at the AR handshake
        reset = 1'b1;
        step(10);
        axi_read(LO, "idle_lo", df, ds, rf, rs);
        check("idle_lo_fast", df, 32'd10);
        check("idle_lo_rresp", rf, OKAY);
        check("idle_lo_slow", ds, 32'd0);
        axi_read(HI, "idle_hi", df, ds, rf, rs);
        check("idle_hi_fast", df, 32'd0);

        // W three cycles ahead of AW, HI := 1; bready held low for 4 cycles
        wdata = 32'h0000_0001; wstrb = 8'h0F; wvalid = 1'b1;
        step(1);
        wvalid = 1'b0; wdata = 32'hFFFF_FFFF;
        check("wfirst_ready", {f_awready, f_wready, f_bvalid}, 3'b100);
        step(2);
        awaddr = HI; awvalid = 1'b1;
        step(1);
        awvalid = 1'b0; awaddr = MISS;
        check("wfirst_bvalid", f_bvalid, 1'b1);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("bhold%0d", i), {f_bvalid, f_bresp}, 3'b100);
            step(1);
        end
        bready = 1'b1;
        step(1);
        bready = 1'b0;
        check("wfirst_bclr", {f_bvalid, f_awready, f_wready}, 3'b011);
        $display("write wfirst addr=%h data=%h", HI, 32'h1);

        // AW three cycles ahead of W, LO := FFFF_FFFE; latched address must be used
        awaddr = LO; awvalid = 1'b1;
        step(1);
        awvalid = 1'b0; awaddr = MISS;
        check("awfirst_ready", {f_awready, f_wready, f_bvalid}, 3'b010);
        step(2);
        wdata = 32'hFFFF_FFFE; wstrb = 8'h0F; wvalid = 1'b1;
        step(1);
        wvalid = 1'b0;
        check("awfirst_bvalid", {f_bvalid, f_bresp}, 3'b100);
        bready = 1'b1;
        step(1);
        bready = 1'b0;
        $display("write awfirst addr=%h data=%h", LO, 32'hFFFF_FFFE);

        // Three ticks after the LO commit: carry into HI
        step(2);
        axi_read(LO, "carry_lo", df, ds, rf, rs);
        check("carry_lo_fast", df, 32'h0000_0001);
        axi_read(HI, "carry_hi", df, ds, rf, rs);
        check("carry_hi_fast", df, 32'h0000_0002);

        // Align to the start of a slow-timer period so its mtime stays still
        guard = 0;
        while ((cyc % 1000) != 1 && guard < 2000) begin
            step(1);
            guard++;
        end
        check("align_guard", guard < 2000, 1'b1);

        for (int i = 0; i < 9; i++) begin
            if (vecs[i].wr_en) begin
                axi_write(vecs[i].waddr, vecs[i].wdata, vecs[i].wstrb, $sformatf("vec%0d", i), bf, bs);
                check($sformatf("vec%0d_bresp", i), bs, vecs[i].exp_bresp);
            end
            axi_read(vecs[i].raddr, $sformatf("vec%0d", i), df, ds, rf, rs);
            check($sformatf("vec%0d_rdata", i), ds, vecs[i].exp_rdata);
            check($sformatf("vec%0d_rresp", i), rs, vecs[i].exp_rresp);
        end

        // Read sampled in the same cycle as a LO commit returns the old value
        araddr = LO; arvalid = 1'b1;
        awaddr = LO; wdata = 32'h5555_5555; wstrb = 8'h0F; awvalid = 1'b1; wvalid = 1'b1;
        step(1);
        arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        check("coll_valid", {s_rvalid, s_bvalid}, 2'b11);
        check("coll_rdata", s_rdata, 32'h1234_AB0D);
        rready = 1'b1; bready = 1'b1;
        step(1);
        rready = 1'b0; bready = 1'b0;
        $display("write coll addr=%h data=%h", LO, 32'h5555_5555);
        axi_read(LO, "coll_after", df, ds, rf, rs);
        check("coll_after_rdata", ds, 32'h5555_5555);

        // Reset while rvalid is pending and a lone W is held
        araddr = HI; arvalid = 1'b1;
        wdata = 32'h0BAD_0BAD; wstrb = 8'h0F; wvalid = 1'b1;
        step(1);
        arvalid = 1'b0; wvalid = 1'b0;
        check("pre_rst_state", {f_rvalid, f_awready, f_wready}, 3'b110);
        #2 reset = 1'b0;
        #1;
        check("midrst_rvalid", {f_rvalid, s_rvalid}, 2'b00);
        check("midrst_ready", {f_awready, f_wready, f_arready}, 3'b111);
        check("midrst_rdata", f_rdata, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        step(3);
        check("post_rst_idle", {f_bvalid, f_rvalid, f_awready, f_wready}, 4'b0011);
        axi_read(LO, "post_rst", df, ds, rf, rs);
        check("post_rst_fast", df, 32'd3);
        check("post_rst_slow", ds, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ysyx_24100006_clint.md
# ysyx_24100006_clint

AXI4-Lite responder implementing the core-local interruptor timer: a free-running 64-bit `mtime` counter exposed as two 32-bit words. It sits behind the crossbar on the CLINT slave port and answers the read and write transactions the crossbar forwards. Read and write channels are independent. Out-of-window addresses return SLVERR.

## Interface
- `BASE_ADDR`, default 32'ha000_0048: address of `mtime[31:0]`; `BASE_ADDR+4` is `mtime[63:32]`.
- `TICK_DIV`, default 1: `mtime` increments once every `TICK_DIV` clocks; legal range 1..65535.
- `READ_LATENCY`, default 1: cycles from AR handshake to `rvalid`; legal range 1..15.

Ports:
- `clk` in 1: single clock; all state on rising edge.
- `reset` in 1: asynchronous, active-low (0 = in reset).
- `s_axi_awvalid` in 1 / `s_axi_awready` out 1 / `s_axi_awaddr` in 32: write address channel.
- `s_axi_wvalid` in 1 / `s_axi_wready` out 1 / `s_axi_wdata` in 32 / `s_axi_wstrb` in 8: write data channel; only `wstrb[3:0]` used.
- `s_axi_bvalid` out 1 / `s_axi_bready` in 1 / `s_axi_bresp` out 2: write response.
- `s_axi_arvalid` in 1 / `s_axi_arready` out 1 / `s_axi_araddr` in 32: read address.
- `s_axi_rvalid` out 1 / `s_axi_rready` in 1 / `s_axi_rdata` out 32 / `s_axi_rresp` out 2: read data.

## Operation
- Decode: `addr[31:2] == BASE_ADDR[31:2]` selects LO, `== (BASE_ADDR+4)[31:2]` selects HI; `addr[1:0]` ignored; anything else is a miss.
- Timer: prescaler counts 0..`TICK_DIV`-1; `mtime` += 1 when the prescaler is at `TICK_DIV`-1; 64-bit wrap 0xFFFF_FFFF_FFFF_FFFF -> 0. Writes to `mtime` do not touch the prescaler.
- Write FSM, states W_IDLE, W_GOT_AW, W_GOT_W, W_RESP:
  - W_IDLE: AW only -> W_GOT_AW (latch addr); W only -> W_GOT_W (latch data/strb); both same cycle -> commit, W_RESP.
  - W_GOT_AW + W handshake, or W_GOT_W + AW handshake -> commit, W_RESP.
  - W_RESP: `bvalid`=1 until `bready`, then W_IDLE.
  - `awready` = state in {W_IDLE, W_GOT_W}; `wready` = state in {W_IDLE, W_GOT_AW}.
- Commit: hit -> for each i in 0..3 with `wstrb[i]`, byte i of selected word := `wdata[8i+7:8i]`, `bresp`=OKAY (2'b00). Miss -> no state change, `bresp`=SLVERR (2'b10).
- A committed write to `mtime` overrides the increment in the same cycle; the other word still holds its pre-increment value.
- Read FSM, states R_IDLE, R_WAIT, R_RESP:
  - R_IDLE: `arready`=1. On handshake, latch addr, load latency counter with `READ_LATENCY`-1; go to R_WAIT, or straight to R_RESP if the value is 0.
  - R_WAIT: decrement; at 0, sample and go to R_RESP.
  - R_RESP: `rvalid`=1 until `rready`, then R_IDLE.
- Sample: `rdata` = current registered `mtime` word, `rresp`=OKAY on hit; `rdata`=0, `rresp`=SLVERR on miss.
- A read sampled in the same cycle as a write commit returns the pre-write value.
- `rdata`/`rresp`/`bresp` are registered and stable while valid is high.

## Timing
- Reset (asserted, asynchronous): `mtime`=0, prescaler=0, both FSMs idle. Outputs: `awready`=1, `wready`=1, `arready`=1, `bvalid`=0, `rvalid`=0, `bresp`=0, `rresp`=0, `rdata`=0.
- Reset asserted mid-transaction aborts it; no response is issued after release.
- Write: `bvalid` rises the cycle after the completing handshake. Minimum: AW+W in cycle N, `bvalid` in N+1.
- Read: `rvalid` rises `READ_LATENCY` cycles after the AR handshake.
- No combinational path from any input to any output. Ready signals decode from state registers only.
- Single outstanding transaction per channel. A new AR is accepted the cycle after the R handshake; B works the same way.

## Structure
- Shared package/header `ysyx_24100006_axi_defs`: response codes OKAY=2'b00, SLVERR=2'b10; write and read FSM state encodings; word offsets LO=0, HI=4.
- One sub-module, `ysyx_24100006_clint_timer`: prescaler plus 64-bit counter, with a byte-strobed write port per word. The top level holds both AXI FSMs and the decode logic.

## Test plan
- Reset release, idle 10 cycles, `TICK_DIV`=1 -> read LO returns 10±`READ_LATENCY` per the sampling cycle, `rresp`=0, HI returns 0.
- Write HI=0x0000_0001 and LO=0xFFFF_FFFE (`wstrb`=0xF), then wait 3 ticks -> HI=0x2, LO=0x1 (carry across words).
- W presented 3 cycles before AW, then AW before W -> each gives one `bvalid` the cycle after the second handshake; `bready` held low 4 cycles keeps `bvalid`/`bresp` stable.
- Write `wstrb`=0x2, `wdata`=0x0000_AB00 to LO with `TICK_DIV`=1000 -> only byte 1 of LO becomes 0xAB.
- Read and write to 0xa000_0050 -> `rresp`=2'b10, `rdata`=0, `bresp`=2'b10, `mtime` unchanged.
- Reset asserted while `rvalid`=1 and `rready`=0 -> `rvalid`=0 immediately, `mtime`=0, all readies 1.
